spi_req_scheduler: RTL

- Round-robin scheduler that shares one SPI master engine between N_REQ requesters (e.g. sensor poller, config loader, debug port).
- Latches one requester's byte and slave select, launches the SPI engine and waits for completion.
- Routes the received byte back to the winner, then enforces an inter-frame gap.
- Sits between client blocks and the SPI master; it is the only block that drives the master's start strobe.

---
 rtl/spi_req_scheduler.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/spi_req_scheduler.sv
// ============================================================================
// spi_req_scheduler : round-robin arbiter sharing one SPI master engine   rev 1.0
// ============================================================================
`default_nettype none

module spi_req_scheduler #(
    parameter int WIDTH      = 8,
    parameter int N_REQ      = 4,
    parameter int SS_W       = 2,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    input  logic [N_REQ*SS_W-1:0]  req_ss,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   rsp_err,
    output logic                   spi_start,
    output logic [WIDTH-1:0]       spi_tx_data,
    output logic [SS_W-1:0]        spi_ss_sel,
    input  logic                   spi_done,
    input  logic [WIDTH-1:0]       spi_rx_data,
    output logic                   busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = 4;
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t             state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   win_q;
    logic [TMO_W-1:0]   tmo_cnt_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [N_REQ-1:0]   rsp_valid_q;
    logic [WIDTH-1:0]   rsp_data_q;
    logic               rsp_err_q;
    logic               spi_start_q;
    logic [WIDTH-1:0]   tx_q;
    logic [SS_W-1:0]    ss_q;

    logic               w_any;
    logic               w_hi_any;
    logic [PTR_W-1:0]   w_lo_idx;
    logic [PTR_W-1:0]   w_hi_idx;
    logic [PTR_W-1:0]   w_win;
    logic [PTR_W-1:0]   w_ptr_d;
    logic [WIDTH-1:0]   w_data;
    logic [SS_W-1:0]    w_ss;

    // Descending scan leaves the lowest set index overall and the lowest at/above the pointer;
    // the latter wins, the former is the wrap-around fallback.
    always_comb begin
        w_any    = 1'b0;
        w_hi_any = 1'b0;
        w_lo_idx = '0;
        w_hi_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_any    = 1'b1;
                w_lo_idx = PTR_W'(i);
                if (PTR_W'(i) >= ptr_q) begin
                    w_hi_any = 1'b1;
                    w_hi_idx = PTR_W'(i);
                end
            end
        end
        w_win   = w_hi_any ? w_hi_idx : w_lo_idx;
        w_ptr_d = (w_win == PTR_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;
    end

    always_comb begin
        w_data = '0;
        w_ss   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win == PTR_W'(i)) begin
                w_data = req_data[i*WIDTH +: WIDTH];
                w_ss   = req_ss[i*SS_W +: SS_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            tmo_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            spi_start_q <= 1'b0;
            tx_q        <= '0;
            ss_q        <= '0;
        end else begin
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            spi_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_any) begin
                        gnt_q   <= ONE_HOT0 << w_win;
                        tx_q    <= w_data;
                        ss_q    <= w_ss;
                        win_q   <= w_win;
                        ptr_q   <= w_ptr_d;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    spi_start_q <= 1'b1;
                    tmo_cnt_q   <= '0;
                    state_q     <= S_WAIT;
                end
                S_WAIT: begin
                    // A done arriving on the final counted cycle still beats the timeout.
                    if (spi_done) begin
                        rsp_data_q  <= spi_rx_data;
                        rsp_valid_q <= ONE_HOT0 << win_q;
                        rsp_err_q   <= 1'b0;
                        gap_cnt_q   <= '0;
                        state_q     <= S_GAP;
                    end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                        rsp_valid_q <= ONE_HOT0 << win_q;
                        rsp_err_q   <= 1'b1;
                        gap_cnt_q   <= '0;
                        state_q     <= S_GAP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt         = gnt_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign spi_start   = spi_start_q;
    assign spi_tx_data = tx_q;
    assign spi_ss_sel  = ss_q;
    assign busy        = (state_q != S_IDLE);

endmodule

`default_nettype wire
